// File: rtl/adder_meas_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_meas_ctrl_pkg
// Purpose : Shared definitions for the adder measurement controller:
//           register offsets, CTRL/STATUS bit indices, FSM state encoding
//           and a Wishbone byte-lane mask helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package adder_meas_ctrl_pkg;

    // Register offsets within the 256-byte window
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_GATE   = 8'h08;
    localparam logic [7:0] OFF_COUNT  = 8'h0C;
    localparam logic [7:0] OFF_A      = 8'h10;
    localparam logic [7:0] OFF_B      = 8'h14;
    localparam logic [7:0] OFF_SUM    = 8'h18;

    // Bit indices
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    // Gate window length after reset
    localparam logic [31:0] GATE_RST = 32'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Expand the 4-bit byte-lane select into a 32-bit bit mask
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage : adder_meas_ctrl_pkg
`default_nettype wire

// File: rtl/adder_meas_ctrl_ro_edge_sync.sv
`default_nettype none
// ============================================================================
// Module  : adder_meas_ctrl_ro_edge_sync
// Purpose : Brings the asynchronous ring-oscillator tap into the clock
//           domain with a two-flop synchroniser and emits a one-cycle pulse
//           on each rising edge of the synchronised signal.
// Ports   : clk_i   - clock
//           rst_i   - synchronous active-high reset
//           async_i - asynchronous input
//           rise_o  - rising-edge pulse (one clock wide)
// Revision: 1.0 - initial release
// ============================================================================
module adder_meas_ctrl_ro_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~hist_q;

endmodule : adder_meas_ctrl_ro_edge_sync
`default_nettype wire

// File: rtl/adder_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adder_meas_ctrl
// Purpose : Wishbone-slave measurement controller. Drives adder operands and
//           the ring-oscillator enable, runs a settle + gate window, counts
//           ring-oscillator rising edges, latches count and adder sum and
//           raises a level interrupt.
// Ports   : wb_clk_i/wb_rst_i      - clock, synchronous active-high reset
//           wbs_*                  - Wishbone slave interface
//           ro_i / ro_en_o         - ring-osc tap (async) / enable
//           a_o, b_o / sum_i       - adder operands / adder result
//           irq_o                  - done & irq_en
// Revision: 1.0 - initial release
// ============================================================================
module adder_meas_ctrl
    import adder_meas_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDER_W   = 8,
    parameter int          CNT_W     = 32,
    parameter int          SETTLE    = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [31:0]        wbs_adr_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic               ro_i,
    output logic               ro_en_o,
    output logic [ADDER_W-1:0] a_o,
    output logic [ADDER_W-1:0] b_o,
    input  logic [ADDER_W:0]   sum_i,
    output logic               irq_o
);

    // Bus-side registers
    logic               ack_q;
    logic [31:0]        dat_q;
    logic               start_q;
    logic               irq_en_q;
    // GATE is kept 32 bits wide so its reset value stays representable
    // even for narrow edge counters.
    logic [31:0]        gate_q;
    logic [ADDER_W-1:0] a_q;
    logic [ADDER_W-1:0] b_q;

    // Measurement-side registers
    state_e             state_q;
    logic               ro_en_q;
    logic               done_q;
    logic [31:0]        settle_q;
    logic [31:0]        gate_cnt_q;
    logic [CNT_W-1:0]   edge_cnt_q;
    logic [CNT_W-1:0]   count_q;
    logic [ADDER_W:0]   sum_q;

    logic               ro_rise;
    logic               w_req;
    logic               w_wr;
    logic               w_busy;
    logic               w_w1c_done;
    logic [7:0]         w_off;
    logic [31:0]        w_mask;
    logic [31:0]        w_rdata;

    adder_meas_ctrl_ro_edge_sync u_sync (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .async_i (ro_i),
        .rise_o  (ro_rise)
    );

    // A new request is only taken when no ack is outstanding, so every
    // access is acked exactly once, one cycle later.
    assign w_off      = wbs_adr_i[7:0];
    assign w_req      = wbs_stb_i & wbs_cyc_i & ~ack_q
                        & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr       = w_req & wbs_we_i;
    assign w_mask     = sel_to_mask(wbs_sel_i);
    assign w_busy     = (state_q == ST_ARM) || (state_q == ST_COUNT);
    assign w_w1c_done = w_wr && (w_off == OFF_STATUS) && wbs_sel_i[0]
                        && wbs_dat_i[STAT_DONE];

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_CTRL:   w_rdata[CTRL_IRQ_EN] = irq_en_q;
            OFF_STATUS: begin
                w_rdata[STAT_BUSY] = w_busy;
                w_rdata[STAT_DONE] = done_q;
            end
            OFF_GATE:   w_rdata = gate_q;
            OFF_COUNT:  w_rdata = 32'(count_q);
            OFF_A:      w_rdata = 32'(a_q);
            OFF_B:      w_rdata = 32'(b_q);
            OFF_SUM:    w_rdata = 32'(sum_q);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            start_q  <= 1'b0;
            irq_en_q <= 1'b0;
            gate_q   <= GATE_RST;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            ack_q   <= w_req;
            dat_q   <= (w_req && !wbs_we_i) ? w_rdata : '0;
            start_q <= 1'b0;  // start is a single-cycle pulse
            if (w_wr) begin
                case (w_off)
                    OFF_CTRL: if (wbs_sel_i[0]) begin
                        start_q  <= wbs_dat_i[CTRL_START];
                        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
                    end
                    OFF_GATE: gate_q <= (gate_q & ~w_mask) | (wbs_dat_i & w_mask);
                    OFF_A:    a_q <= (a_q & ~w_mask[ADDER_W-1:0])
                                     | (wbs_dat_i[ADDER_W-1:0] & w_mask[ADDER_W-1:0]);
                    OFF_B:    b_q <= (b_q & ~w_mask[ADDER_W-1:0])
                                     | (wbs_dat_i[ADDER_W-1:0] & w_mask[ADDER_W-1:0]);
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            ro_en_q    <= 1'b0;
            done_q     <= 1'b0;
            settle_q   <= '0;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            count_q    <= '0;
            sum_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_q) begin
                    state_q    <= ST_ARM;
                    ro_en_q    <= 1'b1;
                    settle_q   <= 32'(SETTLE - 1);
                    edge_cnt_q <= '0;
                end
                ST_ARM: begin
                    if (settle_q == '0) begin
                        if (gate_q == '0) begin
                            state_q <= ST_DONE;
                            ro_en_q <= 1'b0;
                        end else begin
                            state_q    <= ST_COUNT;
                            gate_cnt_q <= gate_q;
                        end
                    end else begin
                        settle_q <= settle_q - 32'd1;
                    end
                end
                ST_COUNT: begin
                    if (ro_rise && (edge_cnt_q != '1))
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                    if (gate_cnt_q == 32'd1) begin
                        state_q <= ST_DONE;
                        ro_en_q <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q - 32'd1;
                    end
                end
                ST_DONE: begin
                    count_q <= edge_cnt_q;
                    sum_q   <= sum_i;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ro_en_q <= 1'b0;
                end
            endcase

            // Hardware set beats a same-cycle software clear
            if (state_q == ST_DONE)
                done_q <= 1'b1;
            else if ((state_q == ST_IDLE) && start_q)
                done_q <= 1'b0;
            else if (w_w1c_done)
                done_q <= 1'b0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign ro_en_o   = ro_en_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign irq_o     = done_q & irq_en_q;

endmodule : adder_meas_ctrl
`default_nettype wire

// File: tb/tb_adder_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_meas_ctrl
// Purpose : Self-checking bench for adder_meas_ctrl. A 32-bit-counter
//           instance sees a slow ring-osc tap, a 4-bit-counter instance
//           shares the bus and sees a fast tap.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_meas_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam int          AW     = 8;
    localparam int          SETTLE = 4;
    localparam int          CLK_P  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          we  = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   wdat = '0;
    logic [31:0]   adr  = '0;
    logic          ro_slow = 1'b0;
    logic          ro_fast = 1'b0;

    logic          ack1, ack2, ro_en1, ro_en2, irq1, irq2;
    logic [31:0]   dat1, dat2;
    logic [AW-1:0] a1, b1, a2, b2;
    logic [AW:0]   sum1, sum2;

    int   total = 0;
    int   bad   = 0;
    logic use2  = 1'b0;
    logic [31:0] exp_q[$];

    // Behavioural model of the instrumented adder
    assign sum1 = {1'b0, a1} + {1'b0, b1};
    assign sum2 = {1'b0, a2} + {1'b0, b2};

    always #(CLK_P/2) clk = ~clk;
    always begin repeat (4) @(negedge clk); ro_slow = ~ro_slow; end
    always begin @(negedge clk); ro_fast = ~ro_fast; end

    adder_meas_ctrl #(.BASE_ADDR(BASE), .ADDER_W(AW), .CNT_W(32), .SETTLE(SETTLE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack1), .wbs_dat_o(dat1), .ro_i(ro_slow), .ro_en_o(ro_en1),
        .a_o(a1), .b_o(b1), .sum_i(sum1), .irq_o(irq1));

    adder_meas_ctrl #(.BASE_ADDR(BASE), .ADDER_W(AW), .CNT_W(4), .SETTLE(SETTLE)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack2), .wbs_dat_o(dat2), .ro_i(ro_fast), .ro_en_o(ro_en2),
        .a_o(a2), .b_o(b2), .sum_i(sum2), .irq_o(irq2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic acked);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        acked = 1'b0; rd = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (use2 ? ack2 : ack1) begin
                acked = 1'b1;
                rd    = use2 ? dat2 : dat1;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        logic        acked;
        bus(1'b1, BASE + 32'(off), d, s, rd, acked);
        chk("wr_ack", 32'(acked), 32'd1);
    endtask

    task automatic rd_raw(input logic [7:0] off, output logic [31:0] rd);
        logic acked;
        bus(1'b0, BASE + 32'(off), '0, 4'hF, rd, acked);
        chk("rd_ack", 32'(acked), 32'd1);
        @(posedge clk); #1;
        chk("ack_1cyc", 32'(use2 ? ack2 : ack1), 32'd0);
    endtask

    // Expected value enters the scoreboard when the read is issued and is
    // retired when the acked data comes back.
    task automatic rd_exp(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        exp_q.push_back(exp);
        rd_raw(off, rd);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else                   chk(tag, rd, exp_q.pop_front());
    endtask

    task automatic wait_irq(input time t0, output int n);
        for (int i = 0; i < 1000; i++) begin
            if (irq1) break;
            @(posedge clk); #1;
        end
        n = int'(($time - t0) / CLK_P);
    endtask

    task automatic start_run(output time t0);
        wr(8'h04, 32'h2, 4'hF);          // clear done first
        wr(8'h00, 32'h3, 4'hF);          // irq_en + start
        t0 = $time;
    endtask

    initial begin
        time         t0;
        int          n;
        logic [31:0] c;
        logic        acked;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_ro_en", 32'(ro_en1), 32'd0);
        chk("rst_irq",   32'(irq1),   32'd0);
        chk("rst_a",     32'(a1),     32'd0);
        rd_exp("rst_ctrl",   8'h00, 32'd0);
        rd_exp("rst_status", 8'h04, 32'd0);
        rd_exp("rst_gate",   8'h08, 32'd16);
        rd_exp("rst_count",  8'h0C, 32'd0);
        rd_exp("rst_a_reg",  8'h10, 32'd0);
        rd_exp("rst_b_reg",  8'h14, 32'd0);
        rd_exp("rst_sum",    8'h18, 32'd0);
        rd_exp("undec_off",  8'h1C, 32'd0);

        // Normal run: GATE=100, slow ring-osc
        wr(8'h10, 32'h7F, 4'hF);
        wr(8'h14, 32'h01, 4'hF);
        chk("a_o", 32'(a1), 32'h7F);
        chk("b_o", 32'(b1), 32'h01);
        wr(8'h08, 32'd100, 4'hF);
        start_run(t0);
        wait_irq(t0, n);
        chk("lat_g100", 32'(n), 32'(SETTLE + 102));
        chk("ro_en_off", 32'(ro_en1), 32'd0);
        rd_raw(8'h0C, c);
        chk("count_12_13", 32'(c >= 32'd12 && c <= 32'd13), 32'd1);
        rd_exp("sum_80",    8'h18, 32'h080);
        rd_exp("st_done",   8'h04, 32'h2);

        // GATE=0: straight from ARM to DONE
        wr(8'h08, 32'd0, 4'hF);
        start_run(t0);
        chk("irq_clr_start", 32'(irq1), 32'd0);
        wait_irq(t0, n);
        chk("lat_g0", 32'(n), 32'(SETTLE + 2));
        chk("irq_set", 32'(irq1), 32'd1);
        rd_exp("count_g0", 8'h0C, 32'd0);
        wr(8'h04, 32'h2, 4'hF);
        chk("irq_w1c", 32'(irq1), 32'd0);
        rd_exp("st_w1c", 8'h04, 32'd0);

        // Saturation on the 4-bit counter instance
        wr(8'h08, 32'd64, 4'hF);
        start_run(t0);
        wait_irq(t0, n);
        chk("lat_g64", 32'(n), 32'(SETTLE + 66));
        use2 = 1'b1;
        rd_exp("count_sat", 8'h0C, 32'hF);
        use2 = 1'b0;

        // Byte-lane write and undecoded address
        wr(8'h08, 32'h10, 4'hF);
        wr(8'h08, 32'h0000_AB00, 4'b0010);
        rd_exp("gate_byte", 8'h08, 32'h0000_AB10);
        bus(1'b0, BASE + 32'h100, '0, 4'hF, c, acked);
        chk("noack_rd", 32'(acked), 32'd0);
        bus(1'b1, BASE + 32'h100, 32'hFF, 4'hF, c, acked);
        chk("noack_wr", 32'(acked), 32'd0);

        // Second start while busy is ignored: latency unchanged
        wr(8'h08, 32'd20, 4'hF);
        start_run(t0);
        repeat (3) @(posedge clk);
        #1;
        wr(8'h00, 32'h3, 4'hF);
        wait_irq(t0, n);
        chk("lat_restart", 32'(n), 32'(SETTLE + 22));
        repeat (3) @(posedge clk);
        #1;
        rd_exp("st_after", 8'h04, 32'h2);

        // Reset in the middle of COUNT
        wr(8'h08, 32'd100, 4'hF);
        start_run(t0);
        repeat (20) @(posedge clk);
        #1;
        chk("ro_en_run", 32'(ro_en1), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ro_en_rst", 32'(ro_en1), 32'd0);
        rst = 1'b0;
        rd_exp("st_rst",    8'h04, 32'd0);
        rd_exp("count_rst", 8'h0C, 32'd0);
        rd_exp("gate_rst",  8'h08, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_adder_meas_ctrl
`default_nettype wire
